pc_config_router: RTL

PC_CONFIG_ROUTER -- requirements
Module: pc_config_router

---
 rtl/pc_config_router.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/pc_config_router.sv
// pc_config_router
// Routes PC input words to one of three destinations, decoded from the word's
// top bits:
//   - BD passthrough FIFO (bit NPCin-1 = 0)
//   - a config register (bit NPCin-2 = 0)
//   - a config channel (bit NPCin-2 = 1), which collects Nwords data fields
//     before presenting them as one output word
// Words whose id is out of range are acknowledged, dropped and counted.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   pc_in_d/v/a           PC word input channel (pc_in_a is combinational)
//   bd_out_d/v/a          BD passthrough output channel
//   conf_chan_d/v/a       per-channel assembled output, valid/ack handshake
//   conf_reg_out/wr       register file contents and one-cycle write strobes
//   conf_reg_reset_vals   static register reset values
//   bad_id_count          saturating count of dropped out-of-range words
module pc_config_router #(
   parameter int unsigned NPCin    = 24,
   parameter int unsigned NBDdata  = 21,
   parameter int unsigned Nconf    = 16,
   parameter int unsigned Nreg     = 32,
   parameter int unsigned Nchan    = 8,
   parameter int unsigned Nwords   = 2,
   parameter int unsigned BD_DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NPCin-1:0]                pc_in_d,
   input  logic                            pc_in_v,
   output logic                            pc_in_a,
   output logic [NBDdata-1:0]              bd_out_d,
   output logic                            bd_out_v,
   input  logic                            bd_out_a,
   output logic [Nchan*Nwords*Nconf-1:0]   conf_chan_d,
   output logic [Nchan-1:0]                conf_chan_v,
   input  logic [Nchan-1:0]                conf_chan_a,
   output logic [Nreg*Nconf-1:0]           conf_reg_out,
   output logic [Nreg-1:0]                 conf_reg_wr,
   input  logic [Nreg*Nconf-1:0]           conf_reg_reset_vals,
   output logic [15:0]                     bad_id_count
);

   localparam int unsigned ID_W  = NPCin - 2 - Nconf;
   localparam int unsigned CW    = Nwords * Nconf;
   localparam int unsigned CNT_W = (Nwords > 1) ? $clog2(Nwords) : 1;
   localparam int unsigned PTR_W = $clog2(BD_DEPTH);

   // Word decode
   logic            w_is_fpga;
   logic            w_is_chan;
   logic [ID_W-1:0] w_id;
   logic [Nconf-1:0] w_data;

   assign w_is_fpga = pc_in_d[NPCin-1];
   assign w_is_chan = pc_in_d[NPCin-2];
   assign w_id      = pc_in_d[NPCin-3:Nconf];
   assign w_data    = pc_in_d[Nconf-1:0];

   // State
   logic [Nconf-1:0]   r_conf_reg [Nreg];
   logic [Nreg-1:0]    r_reg_wr;
   logic [CNT_W-1:0]   r_cnt      [Nchan];
   logic [CW-1:0]      r_buf      [Nchan];
   logic [CW-1:0]      r_chan_d   [Nchan];
   logic [Nchan-1:0]   r_chan_v;
   logic [15:0]        r_bad_cnt;
   logic [NBDdata-1:0] r_bd_mem   [BD_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W:0]     r_bd_cnt;

   // Selected-channel view of the addressed channel (all zero when not a valid channel word)
   logic [Nchan-1:0] w_chan_sel;
   logic [CNT_W-1:0] w_cnt_sel;
   logic [CW-1:0]    w_buf_sel;
   logic             w_chan_busy;
   logic [CW-1:0]    w_assembled;

   always_comb begin
      w_chan_sel  = '0;
      w_cnt_sel   = '0;
      w_buf_sel   = '0;
      w_chan_busy = 1'b0;
      for (int i = 0; i < Nchan; i++) begin
         if (w_is_fpga && w_is_chan && (32'(w_id) == i)) begin
            w_chan_sel[i] = 1'b1;
            w_cnt_sel     = r_cnt[i];
            w_buf_sel     = r_buf[i];
            // output slot still occupied and not being freed this cycle
            w_chan_busy   = r_chan_v[i] & ~conf_chan_a[i];
         end
      end
   end

   // Final word completes the buffer in the top slot
   always_comb begin
      w_assembled = w_buf_sel;
      w_assembled[(Nwords-1)*Nconf +: Nconf] = w_data;
   end

   logic w_chan_ok;
   logic w_reg_ok;
   logic w_final;
   logic w_bd_full;
   logic w_bd_pop;
   logic w_bd_room;

   assign w_chan_ok = |w_chan_sel;
   assign w_reg_ok  = (32'(w_id) < Nreg);
   assign w_final   = (32'(w_cnt_sel) == (Nwords - 1));
   assign w_bd_full = (r_bd_cnt == (PTR_W+1)'(BD_DEPTH));
   assign w_bd_pop  = bd_out_v & bd_out_a;
   // a pop in the same cycle frees a slot, so a full FIFO still accepts
   assign w_bd_room = ~w_bd_full | bd_out_a;

   // Acknowledge: depends on pc_in_d and state/downstream acks, never on pc_in_v
   always_comb begin
      pc_in_a = 1'b1;
      if (!w_is_fpga) begin
         pc_in_a = w_bd_room;
      end else if (w_is_chan && w_chan_ok && w_final && w_chan_busy) begin
         pc_in_a = 1'b0;
      end
   end

   logic w_xfer;
   logic w_bd_push;
   logic w_reg_wr;
   logic w_chan_wr;
   logic w_bad;

   assign w_xfer    = pc_in_v & pc_in_a;
   assign w_bd_push = w_xfer & ~w_is_fpga;
   assign w_reg_wr  = w_xfer & w_is_fpga & ~w_is_chan & w_reg_ok;
   assign w_chan_wr = w_xfer & w_is_fpga & w_is_chan & w_chan_ok;
   assign w_bad     = w_xfer & w_is_fpga & ~(w_is_chan ? w_chan_ok : w_reg_ok);

   // BD FIFO storage (contents need no reset; occupancy governs validity)
   always_ff @(posedge clk) begin
      if (w_bd_push) begin
         r_bd_mem[r_wr_ptr] <= pc_in_d[NBDdata-1:0];
      end
   end

   // BD FIFO pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_bd_cnt <= '0;
      end else begin
         if (w_bd_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_bd_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_bd_push, w_bd_pop})
            2'b10:   r_bd_cnt <= r_bd_cnt + (PTR_W+1)'(1);
            2'b01:   r_bd_cnt <= r_bd_cnt - (PTR_W+1)'(1);
            default: r_bd_cnt <= r_bd_cnt;
         endcase
      end
   end

   assign bd_out_v = (r_bd_cnt != '0);
   assign bd_out_d = r_bd_mem[r_rd_ptr];

   // Config register file with one-cycle write strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < Nreg; i++) begin
            r_conf_reg[i] <= conf_reg_reset_vals[i*Nconf +: Nconf];
         end
         r_reg_wr <= '0;
      end else begin
         r_reg_wr <= '0;
         for (int i = 0; i < Nreg; i++) begin
            if (w_reg_wr && (32'(w_id) == i)) begin
               r_conf_reg[i] <= w_data;
               r_reg_wr[i]   <= 1'b1;
            end
         end
      end
   end

   // Channel deserializers and output slots
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < Nchan; i++) begin
            r_cnt[i]    <= '0;
            r_buf[i]    <= '0;
            r_chan_d[i] <= '0;
         end
         r_chan_v <= '0;
      end else begin
         for (int i = 0; i < Nchan; i++) begin
            if (r_chan_v[i] && conf_chan_a[i]) begin
               r_chan_v[i] <= 1'b0;
            end
            if (w_chan_wr && w_chan_sel[i]) begin
               if (w_final) begin
                  r_chan_d[i] <= w_assembled;
                  r_chan_v[i] <= 1'b1;
                  r_cnt[i]    <= '0;
               end else begin
                  r_buf[i][32'(r_cnt[i])*Nconf +: Nconf] <= w_data;
                  r_cnt[i] <= r_cnt[i] + CNT_W'(1);
               end
            end
         end
      end
   end

   // Saturating drop counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bad_cnt <= '0;
      end else if (w_bad && (r_bad_cnt != 16'hFFFF)) begin
         r_bad_cnt <= r_bad_cnt + 16'd1;
      end
   end

   // Flatten outputs
   genvar g;
   generate
      for (g = 0; g < Nreg; g++) begin : g_reg_out
         assign conf_reg_out[g*Nconf +: Nconf] = r_conf_reg[g];
      end
      for (g = 0; g < Nchan; g++) begin : g_chan_out
         assign conf_chan_d[g*CW +: CW] = r_chan_d[g];
      end
   endgenerate

   assign conf_chan_v  = r_chan_v;
   assign conf_reg_wr  = r_reg_wr;
   assign bad_id_count = r_bad_cnt;

endmodule
